// File: rtl/wb_pkg.sv
// Shared definitions for the register-file write-port arbiter: data and address widths
// and the arbiter state encoding.
package wb_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_PEND  = 2'd1,
        WB_FORCE = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_result_fifo.sv
// Small circular FIFO of MDU results {rd, wdata} waiting for a free write-back slot.
// The caller guarantees no push while full and no pop while empty.
module wb_result_fifo
    import wb_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [REG_ADDR_W-1:0] push_rd_i,
    input  logic [DW-1:0]         push_data_i,
    input  logic                  pop_i,
    output logic [REG_ADDR_W-1:0] head_rd_o,
    output logic [DW-1:0]         head_data_o,
    output logic [CNT_W-1:0]      count_o
);

    logic [REG_ADDR_W-1:0] rd_q   [DEPTH];
    logic [DW-1:0]         data_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                rd_q[wr_ptr_q]   <= push_rd_i;
                data_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q         <= ptr_next(wr_ptr_q);
            end
            if (pop_i) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
            end
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    assign head_rd_o   = rd_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];
    assign count_o     = count_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the pipeline WB stage (priority) and the
// MDU; buffered MDU results are drained by free slots or, after starvation, a forced stall.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN       = wb_pkg::XLEN,
    parameter int BUF_DEPTH  = 2,
    parameter int STARVE_MAX = 4,
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pipe_valid,
    input  logic                  pipe_regwrite,
    input  logic [REG_ADDR_W-1:0] pipe_rd,
    input  logic [XLEN-1:0]       pipe_wdata,
    input  logic                  mdu_valid,
    input  logic [REG_ADDR_W-1:0] mdu_rd,
    input  logic [XLEN-1:0]       mdu_wdata,
    output logic                  mdu_ready,
    output logic                  stall_wb,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    output logic [CNT_W-1:0]      buf_count,
    output wb_state_e             dbg_state
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX - 1);

    wb_state_e             state_q;
    logic [SC_W-1:0]       starve_q;
    logic [CNT_W-1:0]      count_d;
    logic                  pipe_take;
    logic                  buf_nonempty;
    logic                  pop;
    logic                  mdu_keep;
    logic                  direct;
    logic                  push;
    logic [REG_ADDR_W-1:0] head_rd;
    logic [XLEN-1:0]       head_data;

    // Handshake: an MDU result transfers when mdu_valid && mdu_ready. mdu_ready looks only
    // at the registered occupancy, so a full buffer refuses even if it pops this cycle.
    assign stall_wb     = (state_q == WB_FORCE);
    assign mdu_ready    = rst_n && (buf_count < CNT_W'(BUF_DEPTH));
    assign pipe_take    = rst_n && pipe_valid && pipe_regwrite && (pipe_rd != '0) && !stall_wb;
    assign buf_nonempty = (buf_count != '0);
    assign pop          = rst_n && !pipe_take && buf_nonempty;
    assign mdu_keep     = mdu_valid && mdu_ready && (mdu_rd != '0);
    assign direct       = mdu_keep && !pipe_take && !buf_nonempty;
    assign push         = mdu_keep && !direct;
    assign count_d      = buf_count + CNT_W'(push) - CNT_W'(pop);
    assign dbg_state    = state_q;

    wb_result_fifo #(
        .DW    (XLEN),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_rd_i   (mdu_rd),
        .push_data_i (mdu_wdata),
        .pop_i       (pop),
        .head_rd_o   (head_rd),
        .head_data_o (head_data),
        .count_o     (buf_count)
    );

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (pipe_take) begin
            rf_we    = 1'b1;
            rf_waddr = pipe_rd;
            rf_wdata = pipe_wdata;
        end else if (pop) begin
            rf_we    = 1'b1;
            rf_waddr = head_rd;
            rf_wdata = head_data;
        end else if (direct) begin
            rf_we    = 1'b1;
            rf_waddr = mdu_rd;
            rf_wdata = mdu_wdata;
        end
    end

    // starve_q counts consecutive PEND cycles in which the head was not popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= WB_IDLE;
            starve_q <= '0;
        end else begin
            case (state_q)
                WB_IDLE: begin
                    starve_q <= '0;
                    if (push) state_q <= WB_PEND;
                end
                WB_PEND: begin
                    if (pop) begin
                        starve_q <= '0;
                        if (count_d == '0) state_q <= WB_IDLE;
                    end else if (starve_q >= STARVE_LIM) begin
                        starve_q <= '0;
                        state_q  <= WB_FORCE;
                    end else begin
                        starve_q <= starve_q + SC_W'(1);
                    end
                end
                WB_FORCE: begin
                    starve_q <= '0;
                    state_q  <= (count_d == '0) ? WB_IDLE : WB_PEND;
                end
                default: begin
                    starve_q <= '0;
                    state_q  <= WB_IDLE;
                end
            endcase
        end
    end

endmodule
